// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light controller and its phase timer.
package traffic_pkg;

  localparam int CLK_HZ_DEFAULT = 10000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    HOLD  = ST_HOLD
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

endpackage

// File: rtl/phase_timer_if.sv
// Controller-to-timer bundle. REMAINING_OUT_EN adds the seconds-left readback.
interface phase_timer_if #(
  parameter int SEC_W = 16
);
  logic [SEC_W-1:0] timer;
  logic             load;
  logic             pause;
  logic             abort;
  logic             finished;
  logic             done_pulse;
  logic             clamped;
`ifdef REMAINING_OUT_EN
  logic [SEC_W-1:0] remaining;

  modport master (output timer, load, pause, abort,
                  input  finished, done_pulse, clamped, remaining);
  modport slave  (input  timer, load, pause, abort,
                  output finished, done_pulse, clamped, remaining);
`else
  modport master (output timer, load, pause, abort,
                  input  finished, done_pulse, clamped);
  modport slave  (input  timer, load, pause, abort,
                  output finished, done_pulse, clamped);
`endif
endinterface

// File: rtl/phase_timer_tick_prescaler.sv
// Divides clk by CLK_HZ; tick is high on the enabled cycle where the count wraps.
module tick_prescaler #(
  parameter int CLK_HZ = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/phase_timer.sv
// Phase duration countdown in seconds for the light controller.
// Optional REMAINING_OUT_EN exposes the registered seconds-left count.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int SEC_W   = 16,
  parameter int MAX_SEC = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  phase_timer_if.slave bus
);
  state_t           state_q;
  logic [SEC_W-1:0] sec_q;
  logic             finished_q, done_q, clamped_q;
  logic             busy, cnt_en, pre_clr, tick;

  function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] t);
    if (t > SEC_W'(MAX_SEC)) return SEC_W'(MAX_SEC);
    return t;
  endfunction

  // Resuming from HOLD counts on the same edge, so a pause costs exactly its length.
  assign busy    = (state_q != IDLE);
  assign cnt_en  = busy && !bus.pause && !bus.abort;
  assign pre_clr = !busy || bus.abort;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clr),
    .enable  (cnt_en),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      finished_q <= 1'b1;
      done_q     <= 1'b0;
      clamped_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            if (bus.timer == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= COUNT;
              sec_q      <= sat_sec(bus.timer);
              clamped_q  <= (bus.timer > SEC_W'(MAX_SEC));
              finished_q <= 1'b0;
            end
          end
        end
        COUNT, HOLD: begin
          if (bus.abort) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            finished_q <= 1'b1;
          end else if (bus.pause) begin
            state_q <= HOLD;
          end else begin
            state_q <= COUNT;
            if (tick) begin
              sec_q <= sec_q - 1'b1;
              if (sec_q == SEC_W'(1)) begin
                state_q    <= IDLE;
                finished_q <= 1'b1;
                done_q     <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.finished   = finished_q;
  assign bus.done_pulse = done_q;
  assign bus.clamped    = clamped_q;
`ifdef REMAINING_OUT_EN
  assign bus.remaining  = sec_q;
`endif
endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer with CLK_HZ=10: directed scenarios plus random traffic vs. a cycle-budget model.
module tb_phase_timer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  phase_timer_if #(.SEC_W(16)) bus();

  phase_timer #(.CLK_HZ(10), .SEC_W(16), .MAX_SEC(255)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a phase is a budget of clk cycles that only active (unpaused) cycles consume.
  bit m_busy = 0;
  int m_cl = 0;
  bit m_fin = 1, m_done = 0, m_clamp = 0;
  int m_rem = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_cl = 0; m_fin = 1; m_done = 0; m_clamp = 0; m_rem = 0;
      end else begin
        m_done = 0; m_clamp = 0;
        if (!m_busy) begin
          if (bus.load) begin
            if (int'(bus.timer) == 0) m_done = 1;
            else begin
              m_cl    = ((int'(bus.timer) > 255) ? 255 : int'(bus.timer)) * 10;
              m_clamp = (int'(bus.timer) > 255);
              m_busy  = 1;
            end
          end
        end else if (bus.abort) begin
          m_busy = 0; m_cl = 0;
        end else if (!bus.pause) begin
          m_cl--;
          if (m_cl == 0) begin m_busy = 0; m_done = 1; end
        end
        m_fin = !m_busy;
        m_rem = (m_cl + 9) / 10;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("cmp_finished", bus.finished, m_fin);
      chk("cmp_done", bus.done_pulse, m_done);
      chk("cmp_clamped", bus.clamped, m_clamp);
`ifdef REMAINING_OUT_EN
      chk("cmp_remaining", bus.remaining, m_rem);
`endif
    end
  end

  // Called at a negedge; returns at the negedge after the capture edge n.
  task automatic do_load(input int t, output int n);
    bus.timer = 16'(t);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    n = cyc;
  endtask

  task automatic wait_fin(input int budget, output int e);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.finished) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("wait_finished_timeout", ok, 1);
    e = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int n, n2, e;
    bit early;
    bus.timer = '0; bus.load = 0; bus.pause = 0; bus.abort = 0;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus.pause = 1'b1;
    repeat (5) @(negedge clk);
    bus.pause = 1'b0;
    chk("s1_finished", bus.finished, 1);
    chk("s1_done", bus.done_pulse, 0);
    chk("s1_clamped", bus.clamped, 0);

    // 2: timer=3 expires 30 edges after capture
    do_load(3, n);
    early = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k < 30 && bus.finished) early = 0;
`ifdef REMAINING_OUT_EN
      if (k == 1)  chk("s2_rem3", bus.remaining, 3);
      if (k == 10) chk("s2_rem2", bus.remaining, 2);
      if (k == 20) chk("s2_rem1", bus.remaining, 1);
      if (k == 30) chk("s2_rem0", bus.remaining, 0);
`endif
    end
    chk("s2_busy_until_29", early, 1);
    chk("s2_finished_30", bus.finished, 1);
    chk("s2_done_30", bus.done_pulse, 1);
    @(negedge clk);
    chk("s2_done_single", bus.done_pulse, 0);

    // 3: 25-cycle pause delays expiry by 25
    do_load(5, n);
    repeat (20) @(negedge clk);
    bus.pause = 1'b1;
    repeat (25) @(negedge clk);
    bus.pause = 1'b0;
    wait_fin(200, e);
    chk("s3_expiry_edge", e - n, 75);

    // 4: abort, then immediate reload
    do_load(4, n);
    repeat (12) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("s4_abort_finished", bus.finished, 1);
    chk("s4_abort_nodone", bus.done_pulse, 0);
    do_load(2, n2);
    chk("s4_reload_edge", n2 - n, 14);
    chk("s4_reload_busy", bus.finished, 0);
    wait_fin(100, e);
    chk("s4_reload_expiry", e - n2, 20);

    // 5: clamp and zero-length request
    @(negedge clk);
    do_load(300, n);
    chk("s5_clamped_pulse", bus.clamped, 1);
`ifdef REMAINING_OUT_EN
    chk("s5_rem255", bus.remaining, 255);
`endif
    @(negedge clk);
    chk("s5_clamped_single", bus.clamped, 0);
    wait_fin(3000, e);
    chk("s5_clamp_expiry", e - n, 2550);
    @(negedge clk);
    do_load(0, n);
    chk("s5_zero_done", bus.done_pulse, 1);
    chk("s5_zero_finished", bus.finished, 1);
    @(negedge clk);
    chk("s5_zero_done_single", bus.done_pulse, 0);

    // 6: asynchronous reset mid-phase
    do_load(3, n);
    repeat (7) @(negedge clk);
    chk("s6_busy_before", bus.finished, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_async_finished", bus.finished, 1);
    chk("s6_async_done", bus.done_pulse, 0);
    chk("s6_async_clamped", bus.clamped, 0);
`ifdef REMAINING_OUT_EN
    chk("s6_async_rem", bus.remaining, 0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s6_idle_after", bus.finished, 1);

    // Random traffic checked by the compare process
    for (int i = 0; i < 2500; i++) begin
      bus.pause = ($urandom_range(0, 7) == 0);
      bus.abort = ($urandom_range(0, 79) == 0);
      bus.load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0)        bus.timer = '0;
      else if ($urandom_range(0, 199) == 0) bus.timer = 16'($urandom_range(256, 400));
      else                                  bus.timer = 16'($urandom_range(1, 6));
      @(negedge clk);
    end
    bus.pause = 0; bus.abort = 0; bus.load = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
